// File: rtl/tcore_param.sv
// Shared core parameters and types for the return-address-stack repair logic.
package tcore_param;

    localparam int RAS_REPAIR_DEPTH = 4;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } ras_rep_state_e;

endpackage

// File: rtl/ras_repair.sv
// Records speculative RAS pops and, on a flush, re-pushes the unretired ones youngest-first.
// Optional macro RAS_REPAIR_STATS_EN adds saturating replay/overflow event counters.
module ras_repair
    import tcore_param::*;
#(
    parameter int DEPTH = RAS_REPAIR_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spec_pop_i,
    input  logic [31:0] spec_pop_addr_i,
    input  logic        resolve_valid_i,
    input  logic        flush_i,
    output logic        restore_o,
    output logic [31:0] restore_pc_o,
    output logic        busy_o,
    output logic        overflow_o
`ifdef RAS_REPAIR_STATS_EN
    ,
    output logic [15:0] replay_cnt_o,
    output logic [15:0] overflow_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ras_rep_state_e state_q, state_d;
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d, tail_m1;
    logic [CW-1:0]  count_q, count_d, cnt_res;
    logic           ovf_q, ovf_d, wr_en;
    logic [31:0]    mem_q [DEPTH];

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cnt_res = count_q;
        ovf_d   = 1'b0;
        wr_en   = 1'b0;
        tail_m1 = tail_q - PW'(1);
        if (state_q == IDLE) begin
            // Retire first, then enqueue, then flush sees the combined result.
            if (resolve_valid_i && count_q != '0) begin
                head_d  = head_q + PW'(1);
                cnt_res = count_q - CW'(1);
            end
            count_d = cnt_res;
            if (spec_pop_i) begin
                wr_en  = 1'b1;
                tail_d = tail_q + PW'(1);
                if (cnt_res == CW'(DEPTH)) begin
                    head_d = head_d + PW'(1);
                    ovf_d  = 1'b1;
                end else begin
                    count_d = cnt_res + CW'(1);
                end
            end
            if (flush_i) begin
                if (count_d != '0) begin
                    state_d = REPLAY;
                end else begin
                    head_d = '0;
                    tail_d = '0;
                end
            end
        end else begin
            tail_d  = tail_m1;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[tail_q] <= spec_pop_addr_i;
    end

    // Outputs decode straight from state so reset removes them without waiting a clock.
    assign restore_o    = (state_q == REPLAY);
    assign busy_o       = (state_q == REPLAY);
    assign restore_pc_o = restore_o ? mem_q[tail_m1] : 32'h0;
    assign overflow_o   = ovf_q;

`ifdef RAS_REPAIR_STATS_EN
    logic [15:0] replay_cnt_q, overflow_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            replay_cnt_q   <= '0;
            overflow_cnt_q <= '0;
        end else begin
            if (state_q == REPLAY && replay_cnt_q != 16'hFFFF)
                replay_cnt_q <= replay_cnt_q + 16'd1;
            if (ovf_d && overflow_cnt_q != 16'hFFFF)
                overflow_cnt_q <= overflow_cnt_q + 16'd1;
        end
    end

    assign replay_cnt_o   = replay_cnt_q;
    assign overflow_cnt_o = overflow_cnt_q;
`endif

endmodule

// File: doc/ras_repair.md
RAS_REPAIR -- requirements
Module: ras_repair

Interface
REQ-001 Parameter DEPTH, default 4, power of two >= 2; in-flight speculative-pop capacity.
REQ-002 clk_i  in  1  sole clock; all state on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 spec_pop_i  in  1  RAS performed a speculative POP this cycle.
REQ-005 spec_pop_addr_i  in  32  address removed from RAS top by that POP.
REQ-006 resolve_valid_i  in  1  oldest in-flight return resolved at execute; its pop is architecturally real.
REQ-007 flush_i  in  1  pipeline flush; all unretired pops are wrong-path and must be undone.
REQ-008 restore_o  out  1  push restore_pc_o onto RAS this cycle; drives RAS restore input.
REQ-009 restore_pc_o  out  32  address to re-push.
REQ-010 busy_o  out  1  replay in progress; fetch must stall and hold spec_pop_i low.
REQ-011 overflow_o  out  1  one-cycle pulse: oldest entry discarded on a full push.

Function
REQ-012 Storage SHALL be a DEPTH-entry circular FIFO with head, tail and count ($clog2(DEPTH)+1 bits); all pointers wrap modulo DEPTH.
REQ-013 FSM SHALL have states IDLE and REPLAY.
REQ-014 IDLE, spec_pop_i=1: write spec_pop_addr_i at tail, tail+1, count+1.
REQ-015 IDLE, resolve_valid_i=1 with count>0: head+1, count-1; resolve_valid_i with count=0 SHALL be ignored.
REQ-016 Same-cycle resolve and spec_pop SHALL both apply; count unchanged.
REQ-017 Full (count=DEPTH) and spec_pop_i without resolve: write at tail, head+1, count stays DEPTH, overflow_o=1 next cycle only.
REQ-018 Same-cycle ordering: resolve retires head first, then spec_pop is enqueued, then flush is evaluated on the result.
REQ-019 IDLE, flush_i=1: if resulting count>0 go REPLAY next cycle; else stay IDLE and clear pointers.
REQ-020 REPLAY: each cycle restore_o=1, restore_pc_o=entry at tail-1, tail-1, count-1; youngest pop re-pushed first, oldest last, reproducing original stack order.
REQ-021 First restore_o SHALL occur the cycle after flush_i; replay of N entries lasts exactly N cycles; return to IDLE after last entry, count=0.
REQ-022 busy_o SHALL equal (state==REPLAY).
REQ-023 In REPLAY, spec_pop_i, resolve_valid_i and flush_i SHALL be ignored.
REQ-024 restore_o SHALL be 0 in IDLE; restore_pc_o SHALL be 0 whenever restore_o=0.

Reset
REQ-025 rst_i SHALL immediately force IDLE, head=tail=count=0, restore_o=0, restore_pc_o=0, busy_o=0, overflow_o=0; assertion mid-REPLAY abandons replay.
REQ-026 FIFO data array need not be reset.

Configuration
REQ-027 Macro RAS_REPAIR_STATS_EN: when defined, add outputs replay_cnt_o (16, number of REPLAY entries) and overflow_cnt_o (16, overflow events), both saturating at 16'hFFFF, reset to 0; when undefined, these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-028 Enum ras_rep_state_e (IDLE, REPLAY) and localparam RAS_REPAIR_DEPTH SHALL live in tcore_param.
REQ-029 No sub-module; FIFO and FSM inline in ras_repair.

Verification
REQ-030 Pops 0x100,0x200,0x300, then flush -> restore_o 3 cycles with 0x300,0x200,0x100; busy_o 3 cycles; then IDLE.
REQ-031 Pops 0x100,0x200; resolve_valid_i+flush_i same cycle -> single restore of 0x200 only.
REQ-032 DEPTH=4, five pops 0x10..0x50 -> overflow_o pulse after fifth; flush replays 0x50,0x40,0x30,0x20.
REQ-033 Pop 0xA0 and flush same cycle from empty -> one restore of 0xA0.
REQ-034 rst_i asserted on second replay cycle of a 3-entry replay -> restore_o, busy_o drop immediately; later flush with no pops yields no restore.
REQ-035 With RAS_REPAIR_STATS_EN: after REQ-030 and REQ-032 sequences, replay_cnt_o=7, overflow_cnt_o=1.
